// File: rtl/hack_pkg.sv
// Shared constants and types for the Hack CPU datapath blocks.
package hack_pkg;

   localparam int unsigned WORD_W = 16;

   // Requester identities on the shared incrementer
   localparam logic REQ_PC = 1'b0;
   localparam logic REQ_SP = 1'b1;

   localparam logic [WORD_W-1:0] WORD_ONES = 16'hFFFF;

   // Occupancy of the single-entry result buffer
   typedef enum logic {
      BUF_EMPTY = 1'b0,
      BUF_FULL  = 1'b1
   } buf_state_t;

endpackage

// File: rtl/inc16.sv
// Combinational 16-bit incrementer: out = in + 1, modulo 2^16.
module inc16
   import hack_pkg::*;
(
   input  logic [WORD_W-1:0] in,
   output logic [WORD_W-1:0] out
);

   assign out = in + {{(WORD_W-1){1'b0}}, 1'b1};

endmodule

// File: rtl/inc16_arbiter.sv
// Round-robin share of one inc16 between two valid/ready requesters,
// with a registered single-entry result buffer tagged by requester.
module inc16_arbiter
   import hack_pkg::*;
#(
   parameter int unsigned WIDTH     = 16,
   parameter bit          FIRST_REQ = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0_valid,
   input  logic [WIDTH-1:0] req0_data,
   output logic             req0_ready,
   input  logic             req1_valid,
   input  logic [WIDTH-1:0] req1_data,
   output logic             req1_ready,
   output logic             res_valid,
   output logic [WIDTH-1:0] res_data,
   output logic             res_id,
   output logic             res_wrap,
   input  logic             res_ready
);

   buf_state_t       state_p1;
   logic [WIDTH-1:0] data_p1;
   logic             id_p1;
   logic             wrap_p1;
   logic             last_grant;

   logic             grant_vld;
   logic             grant_id;
   logic             can_accept;
   logic             accept;
   logic [WIDTH-1:0] operand_p0;
   logic [WIDTH-1:0] sum_p0;
   logic             wrap_p0;

   // Round-robin grant: a lone requester wins; on contention the one not served last wins
   always_comb begin
      grant_vld = 1'b0;
      grant_id  = REQ_PC;
      if (req0_valid && req1_valid) begin
         grant_vld = 1'b1;
         grant_id  = ~last_grant;
      end else if (req0_valid) begin
         grant_vld = 1'b1;
         grant_id  = REQ_PC;
      end else if (req1_valid) begin
         grant_vld = 1'b1;
         grant_id  = REQ_SP;
      end
   end

   // The buffer can take a new result when empty or being drained this cycle
   assign can_accept = (state_p1 == BUF_EMPTY) || res_ready;
   assign accept     = grant_vld && can_accept && !reset;

   assign req0_ready = can_accept && grant_vld && (grant_id == REQ_PC) && !reset;
   assign req1_ready = can_accept && grant_vld && (grant_id == REQ_SP) && !reset;

   // ---- stage p0: operand select and increment ----
   assign operand_p0 = (grant_id == REQ_SP) ? req1_data : req0_data;
   assign wrap_p0    = (operand_p0 == WORD_ONES);

   inc16 u_inc16 (
      .in  (operand_p0),
      .out (sum_p0)
   );

   // ---- stage p1: result buffer ----
   // Buffer state machine: fill on accept, empty on drain without refill
   always_ff @(posedge clk) begin
      if (reset) begin
         state_p1   <= BUF_EMPTY;
         data_p1    <= '0;
         id_p1      <= 1'b0;
         wrap_p1    <= 1'b0;
         last_grant <= ~FIRST_REQ;
      end else if (accept) begin
         state_p1   <= BUF_FULL;
         data_p1    <= sum_p0;
         id_p1      <= grant_id;
         wrap_p1    <= wrap_p0;
         last_grant <= grant_id;
      end else if ((state_p1 == BUF_FULL) && res_ready) begin
         state_p1   <= BUF_EMPTY;
      end
   end

   assign res_valid = (state_p1 == BUF_FULL);
   assign res_data  = data_p1;
   assign res_id    = id_p1;
   assign res_wrap  = wrap_p1;

endmodule

// File: tb/tb_inc16_arbiter.sv
// Directed-vector bench for inc16_arbiter.
module tb_inc16_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        req0_valid, req1_valid;
   logic [15:0] req0_data, req1_data;
   logic        req0_ready, req1_ready;
   logic        res_valid, res_id, res_wrap, res_ready;
   logic [15:0] res_data;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   inc16_arbiter #(.WIDTH(16), .FIRST_REQ(1'b0)) dut (
      .clk        (clk),
      .reset      (reset),
      .req0_valid (req0_valid),
      .req0_data  (req0_data),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_data  (req1_data),
      .req1_ready (req1_ready),
      .res_valid  (res_valid),
      .res_data   (res_data),
      .res_id     (res_id),
      .res_wrap   (res_wrap),
      .res_ready  (res_ready)
   );

   // advance past the next rising edge; inputs change here
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; res_ready = 1'b1;
      req0_valid = 1'b1; req0_data = 16'h1111;
      req1_valid = 1'b1; req1_data = 16'h2222;
      @(negedge clk);
      checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL rst_rdy0 got %b exp 0", req0_ready); end
      checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL rst_rdy1 got %b exp 0", req1_ready); end
      tick();
      reset = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
      @(negedge clk);
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", res_valid); end
      checks++; if (res_data !== 16'h0000) begin errors++; $display("FAIL rst_data got %h exp 0000", res_data); end
      checks++; if (res_id !== 1'b0) begin errors++; $display("FAIL rst_id got %b exp 0", res_id); end
      checks++; if (res_wrap !== 1'b0) begin errors++; $display("FAIL rst_wrap got %b exp 0", res_wrap); end
   endtask

   task automatic test_contested();
      logic [15:0] exp_d [4] = '{16'h1235, 16'h0001, 16'h0101, 16'h0201};
      logic        exp_i [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
      tick();
      res_ready = 1'b1;
      req0_valid = 1'b1; req0_data = 16'h1234;
      req1_valid = 1'b1; req1_data = 16'h0000;
      @(negedge clk);
      checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL cont_first_grant got %b exp 10", {req0_ready, req1_ready}); end
      for (int i = 0; i < 4; i++) begin
         tick();
         if (i == 0) req0_data = 16'h0100;
         if (i == 1) req1_data = 16'h0200;
         if (i == 3) begin req0_valid = 1'b0; req1_valid = 1'b0; end
         @(negedge clk);
         checks++; if (res_valid !== 1'b1 || res_data !== exp_d[i] || res_id !== exp_i[i])
            begin errors++; $display("FAIL cont_res%0d got v%b %h id%b exp v1 %h id%b", i, res_valid, res_data, res_id, exp_d[i], exp_i[i]); end
         if (i < 3) begin
            checks++; if (req1_ready !== ~exp_i[i] || req0_ready !== exp_i[i])
               begin errors++; $display("FAIL cont_alt%0d got rdy0 %b rdy1 %b exp rdy1 %b", i, req0_ready, req1_ready, ~exp_i[i]); end
         end
      end
      tick();
      @(negedge clk);
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL cont_drain got %b exp 0", res_valid); end
   endtask

   task automatic test_single();
      req0_valid = 1'b1; req0_data = 16'h0005;
      @(negedge clk);
      checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL single_rdy got %b exp 10", {req0_ready, req1_ready}); end
      tick();
      req0_valid = 1'b0;
      @(negedge clk);
      checks++; if (res_valid !== 1'b1 || res_data !== 16'h0006 || res_id !== 1'b0 || res_wrap !== 1'b0)
         begin errors++; $display("FAIL single_res got v%b %h id%b w%b exp v1 0006 id0 w0", res_valid, res_data, res_id, res_wrap); end
      tick();
      @(negedge clk);
      checks++; if (res_valid !== 1'b0 || res_data !== 16'h0006)
         begin errors++; $display("FAIL single_drain got v%b %h exp v0 0006", res_valid, res_data); end
   endtask

   task automatic test_wrap();
      req1_valid = 1'b1; req1_data = 16'hFFFF;
      @(negedge clk);
      checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL wrap_rdy1 got %b exp 1", req1_ready); end
      tick();
      req1_valid = 1'b0; req0_valid = 1'b1; req0_data = 16'h0001;
      @(negedge clk);
      checks++; if (res_valid !== 1'b1 || res_data !== 16'h0000 || res_id !== 1'b1 || res_wrap !== 1'b1)
         begin errors++; $display("FAIL wrap_ffff got v%b %h id%b w%b exp v1 0000 id1 w1", res_valid, res_data, res_id, res_wrap); end
      checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL wrap_rdy0 got %b exp 1", req0_ready); end
      tick();
      req0_valid = 1'b0;
      @(negedge clk);
      checks++; if (res_data !== 16'h0002 || res_id !== 1'b0 || res_wrap !== 1'b0)
         begin errors++; $display("FAIL wrap_0001 got %h id%b w%b exp 0002 id0 w0", res_data, res_id, res_wrap); end
      tick();
   endtask

   task automatic test_backpressure();
      res_ready = 1'b0;
      req0_valid = 1'b1; req0_data = 16'h0005;
      @(negedge clk);
      checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL bp_accept got %b exp 1", req0_ready); end
      tick();
      req0_valid = 1'b0; req1_valid = 1'b1; req1_data = 16'h0AAA;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++; if (res_valid !== 1'b1 || res_data !== 16'h0006 || res_id !== 1'b0)
            begin errors++; $display("FAIL bp_hold%0d got v%b %h id%b exp v1 0006 id0", i, res_valid, res_data, res_id); end
         checks++; if ({req0_ready, req1_ready} !== 2'b00)
            begin errors++; $display("FAIL bp_rdy%0d got %b exp 00", i, {req0_ready, req1_ready}); end
         tick();
      end
      res_ready = 1'b1;
      @(negedge clk);
      checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL bp_refill_rdy got %b exp 1", req1_ready); end
      tick();
      req1_valid = 1'b0;
      @(negedge clk);
      checks++; if (res_valid !== 1'b1 || res_data !== 16'h0AAB || res_id !== 1'b1)
         begin errors++; $display("FAIL bp_refill got v%b %h id%b exp v1 0aab id1", res_valid, res_data, res_id); end
      tick();
   endtask

   task automatic test_reset_full();
      res_ready = 1'b0;
      req1_valid = 1'b1; req1_data = 16'h0123;
      tick();
      req1_valid = 1'b0;
      @(negedge clk);
      checks++; if (res_valid !== 1'b1 || res_data !== 16'h0124)
         begin errors++; $display("FAIL rf_full got v%b %h exp v1 0124", res_valid, res_data); end
      tick();
      reset = 1'b1;
      req0_valid = 1'b1; req0_data = 16'h0050;
      req1_valid = 1'b1; req1_data = 16'h0060;
      @(negedge clk);
      checks++; if ({req0_ready, req1_ready} !== 2'b00)
         begin errors++; $display("FAIL rf_rst_rdy got %b exp 00", {req0_ready, req1_ready}); end
      tick();
      reset = 1'b0; res_ready = 1'b1;
      @(negedge clk);
      checks++; if (res_valid !== 1'b0 || res_data !== 16'h0000)
         begin errors++; $display("FAIL rf_cleared got v%b %h exp v0 0000", res_valid, res_data); end
      checks++; if ({req0_ready, req1_ready} !== 2'b10)
         begin errors++; $display("FAIL rf_first_grant got %b exp 10", {req0_ready, req1_ready}); end
      tick();
      req0_valid = 1'b0;
      @(negedge clk);
      checks++; if (res_data !== 16'h0051 || res_id !== 1'b0 || req1_ready !== 1'b1)
         begin errors++; $display("FAIL rf_res0 got %h id%b rdy1 %b exp 0051 id0 rdy1 1", res_data, res_id, req1_ready); end
      tick();
      req1_valid = 1'b0;
      @(negedge clk);
      checks++; if (res_valid !== 1'b1 || res_data !== 16'h0061 || res_id !== 1'b1)
         begin errors++; $display("FAIL rf_res1 got v%b %h id%b exp v1 0061 id1", res_valid, res_data, res_id); end
   endtask

   initial begin
      test_reset();
      test_contested();
      test_single();
      test_wrap();
      test_backpressure();
      test_reset_full();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
